btb_access_ctrl: RTL and testbench
==================================

Name: btb_access_ctrl

Overview:
- Sequences the single shared access port of the 4-way BTB among three clients: fetch-stage lookups, execute-stage updates (branch resolution), and a full-table invalidate sweep.
- Arbitrates lookup against update with a bounded-starvation priority scheme.
- Returns registered lookup results to fetch.
- Runs a multi-cycle invalidate FSM that clears every set after a pipeline flush or context switch.

Parameters:
- NUM_BTB_ENTRIES, 16: number of sets in each way. IDX_W = $clog2(NUM_BTB_ENTRIES).
- TAG_WIDTH, 5: width of the tag field.
- TARGET_WIDTH, 32: width of a branch target.
- MAX_UP_STREAK, 2: maximum number of consecutive update grants while a lookup is pending. Legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- lk_req  in  1  lookup request; held until lk_gnt.
- lk_index  in  IDX_W  lookup set index.
- lk_tag  in  TAG_WIDTH  lookup tag.
- lk_gnt  out  1  lookup accepted this cycle.
- lk_rsp_valid  out  1  lookup result valid (one-cycle pulse).
- lk_rsp_hit  out  1  lookup hit.
- lk_rsp_target  out  TARGET_WIDTH  predicted target (0 on miss).
- up_req  in  1  update request; held until up_gnt.
- up_index  in  IDX_W  update set index.
- up_tag  in  TAG_WIDTH  update tag.
- up_target  in  TARGET_WIDTH  resolved target.
- up_gnt  out  1  update accepted this cycle.
- inv_req  in  1  start an invalidate sweep (level or pulse).
- inv_busy  out  1  sweep in progress.
- inv_done  out  1  one-cycle pulse after the last set is cleared.
- btb_index  out  IDX_W  BTB port index.
- btb_tag  out  TAG_WIDTH  BTB port tag.
- btb_target  out  TARGET_WIDTH  BTB port write data.
- btb_rd  out  1  lookup strobe.
- btb_wr  out  1  update/allocate strobe.
- btb_inv  out  1  invalidate all ways at btb_index.
- btb_hit  in  1  BTB combinational hit for the current port access.
- btb_target_rd  in  TARGET_WIDTH  BTB combinational target.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; streak counter 0; sweep counter 0.
- FSM states are IDLE and SWEEP.
- IDLE, one grant per cycle, combinational in the same cycle as the request:
  - If inv_req=1, no grant is issued. Next state is SWEEP with the counter at 0.
  - Otherwise, if up_req=1 and (lk_req=0 or streak < MAX_UP_STREAK): up_gnt=1 and btb_wr=1, with btb_index/tag/target taken from the up_* inputs. Streak increments (saturating) if lk_req=1, otherwise it clears.
  - Otherwise, if lk_req=1: lk_gnt=1, btb_rd=1, btb_index/tag taken from lk_*, btb_target=0. Streak clears.
  - Otherwise the port is idle: all strobes 0 and btb_* = 0.
- Lookup latency is 1 cycle. btb_hit and btb_target_rd are sampled at the edge ending the lk_gnt cycle. lk_rsp_valid=1 in the next cycle with lk_rsp_hit=btb_hit and lk_rsp_target=(btb_hit ? btb_target_rd : 0). A response is never suppressed, including when inv_req arrives in that cycle.
- SWEEP:
  - Each cycle: btb_inv=1, btb_index=counter, btb_rd=btb_wr=0, lk_gnt=up_gnt=0, inv_busy=1.
  - The counter increments by 1 each cycle. On the cycle the counter equals NUM_BTB_ENTRIES-1, the next state is IDLE and inv_done pulses in the following cycle. A full sweep therefore takes exactly NUM_BTB_ENTRIES cycles.
  - inv_req asserted during SWEEP restarts the counter at 0 in the next cycle. inv_done fires only after an uninterrupted pass.
  - Pending requests remain held by the requesters and are served from the first IDLE cycle, with normal arbitration. The streak counter clears on SWEEP entry.
- Simultaneous inv_req, up_req and lk_req in IDLE: the sweep wins and neither request is granted that cycle.
- Requester contract: request signals and payloads are stable while req=1 and gnt=0. The controller does not check this.
- rst asserted mid-sweep aborts the sweep; inv_done does not fire. rst asserted in a grant cycle drops any pending lk_rsp_valid.
- The arithmetic width of the sweep counter is IDX_W+1, so terminal detection works without wrap for a power-of-two NUM_BTB_ENTRIES.

Test Plan:
- Lookup only: lk_req=1, lk_index=3, lk_tag=5'h0A, with the BTB model returning hit and target 32'h0000_1040 -> lk_gnt in cycle 0; lk_rsp_valid=1, hit=1, target=32'h0000_1040 in cycle 1. The same request with a miss -> hit=0, target=0.
- Starvation bound: up_req and lk_req held continuously, MAX_UP_STREAK=2 -> grant sequence up, up, lk, up, up, lk.
- Update only: up_req=1, index=7, tag=5'h11, target=32'hDEAD_BEE0 -> same-cycle up_gnt=1, btb_wr=1 and matching btb_* values; streak stays 0.
- Sweep: inv_req pulse with lk_req held -> btb_inv=1 for 16 cycles with btb_index 0..15; inv_busy=1 throughout; inv_done in cycle 17; lk_gnt in the first IDLE cycle.
- Sweep restart: inv_req reasserted when the counter is 9 -> the counter returns to 0; inv_done occurs 16 cycles after the restart, not earlier.
- Reset mid-sweep: rst at counter 5 -> next cycle all outputs 0 and IDLE; no inv_done; a subsequent lk_req is granted immediately.

Source files
------------

// File: rtl/btb_access_ctrl.sv
// btb_access_ctrl: sequences the single shared BTB access port among fetch
// lookups, execute-stage updates and a full-table invalidate sweep.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   lk_*            fetch lookup request/grant and registered response
//   up_*            branch-resolution update request/grant
//   inv_req         start (or restart) an invalidate sweep
//   inv_busy        sweep in progress
//   inv_done        one-cycle pulse after an uninterrupted sweep completes
//   btb_*           shared BTB port: index/tag/target, rd/wr/inv strobes,
//                   combinational hit/target returned by the BTB
module btb_access_ctrl #(
    parameter int unsigned NUM_BTB_ENTRIES = 16,
    parameter int unsigned TAG_WIDTH       = 5,
    parameter int unsigned TARGET_WIDTH    = 32,
    parameter int unsigned MAX_UP_STREAK   = 2,
    localparam int unsigned IDX_W          = $clog2(NUM_BTB_ENTRIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lk_req,
    input  logic [IDX_W-1:0]        lk_index,
    input  logic [TAG_WIDTH-1:0]    lk_tag,
    output logic                    lk_gnt,
    output logic                    lk_rsp_valid,
    output logic                    lk_rsp_hit,
    output logic [TARGET_WIDTH-1:0] lk_rsp_target,
    input  logic                    up_req,
    input  logic [IDX_W-1:0]        up_index,
    input  logic [TAG_WIDTH-1:0]    up_tag,
    input  logic [TARGET_WIDTH-1:0] up_target,
    output logic                    up_gnt,
    input  logic                    inv_req,
    output logic                    inv_busy,
    output logic                    inv_done,
    output logic [IDX_W-1:0]        btb_index,
    output logic [TAG_WIDTH-1:0]    btb_tag,
    output logic [TARGET_WIDTH-1:0] btb_target,
    output logic                    btb_rd,
    output logic                    btb_wr,
    output logic                    btb_inv,
    input  logic                    btb_hit,
    input  logic [TARGET_WIDTH-1:0] btb_target_rd
);

    // One extra bit so the terminal count never wraps for power-of-two sizes.
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned STK_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BTB_ENTRIES - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_UP_STREAK);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [STK_W-1:0]        streak_q, streak_d;
    logic                    done_d;
    logic                    rsp_valid_q;
    logic                    rsp_hit_q;
    logic [TARGET_WIDTH-1:0] rsp_target_q;
    logic                    done_q;

    // Arbitration, port muxing and sweep sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        done_d     = 1'b0;
        lk_gnt     = 1'b0;
        up_gnt     = 1'b0;
        inv_busy   = 1'b0;
        btb_index  = '0;
        btb_tag    = '0;
        btb_target = '0;
        btb_rd     = 1'b0;
        btb_wr     = 1'b0;
        btb_inv    = 1'b0;

        // Grants and strobes stay low while reset is asserted.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (inv_req) begin
                        state_d  = SWEEP;
                        cnt_d    = '0;
                        streak_d = '0;
                    end else if (up_req && (!lk_req || (streak_q < STK_MAX))) begin
                        up_gnt     = 1'b1;
                        btb_wr     = 1'b1;
                        btb_index  = up_index;
                        btb_tag    = up_tag;
                        btb_target = up_target;
                        // Only count updates that actually delay a waiting lookup.
                        if (!lk_req) begin
                            streak_d = '0;
                        end else if (streak_q != STK_MAX) begin
                            streak_d = STK_W'(streak_q + STK_W'(1));
                        end
                    end else if (lk_req) begin
                        lk_gnt    = 1'b1;
                        btb_rd    = 1'b1;
                        btb_index = lk_index;
                        btb_tag   = lk_tag;
                        streak_d  = '0;
                    end
                end
                SWEEP: begin
                    inv_busy  = 1'b1;
                    btb_inv   = 1'b1;
                    btb_index = cnt_q[IDX_W-1:0];
                    if (inv_req) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
            endcase
        end
    end

    // State, counters and the registered lookup response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            streak_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_target_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            streak_q     <= streak_d;
            rsp_valid_q  <= lk_gnt;
            rsp_hit_q    <= lk_gnt & btb_hit;
            rsp_target_q <= (lk_gnt && btb_hit) ? btb_target_rd : '0;
            done_q       <= done_d;
        end
    end

    assign lk_rsp_valid  = rsp_valid_q;
    assign lk_rsp_hit    = rsp_hit_q;
    assign lk_rsp_target = rsp_target_q;
    assign inv_done      = done_q;

endmodule

// File: tb/tb_btb_access_ctrl.sv
// Bench for btb_access_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a rule-level model and a small 4-way BTB.
module tb_btb_access_ctrl;

    localparam int N     = 16;
    localparam int IW    = 4;
    localparam int TW    = 5;
    localparam int GW    = 32;
    localparam int MAXS  = 2;
    localparam int WAYS  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          lk_req;
    logic [IW-1:0] lk_index;
    logic [TW-1:0] lk_tag;
    logic          lk_gnt;
    logic          lk_rsp_valid;
    logic          lk_rsp_hit;
    logic [GW-1:0] lk_rsp_target;
    logic          up_req;
    logic [IW-1:0] up_index;
    logic [TW-1:0] up_tag;
    logic [GW-1:0] up_target;
    logic          up_gnt;
    logic          inv_req;
    logic          inv_busy;
    logic          inv_done;
    logic [IW-1:0] btb_index;
    logic [TW-1:0] btb_tag;
    logic [GW-1:0] btb_target;
    logic          btb_rd;
    logic          btb_wr;
    logic          btb_inv;
    logic          btb_hit;
    logic [GW-1:0] btb_target_rd;

    btb_access_ctrl #(
        .NUM_BTB_ENTRIES(N), .TAG_WIDTH(TW), .TARGET_WIDTH(GW), .MAX_UP_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag), .lk_gnt(lk_gnt),
        .lk_rsp_valid(lk_rsp_valid), .lk_rsp_hit(lk_rsp_hit), .lk_rsp_target(lk_rsp_target),
        .up_req(up_req), .up_index(up_index), .up_tag(up_tag), .up_target(up_target),
        .up_gnt(up_gnt), .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done),
        .btb_index(btb_index), .btb_tag(btb_tag), .btb_target(btb_target),
        .btb_rd(btb_rd), .btb_wr(btb_wr), .btb_inv(btb_inv),
        .btb_hit(btb_hit), .btb_target_rd(btb_target_rd)
    );

    always #5 clk = ~clk;

    // BTB storage
    logic          sv  [N][WAYS];
    logic [TW-1:0] st  [N][WAYS];
    logic [GW-1:0] stg [N][WAYS];
    int            rr  [N];

    always_comb begin
        btb_hit       = 1'b0;
        btb_target_rd = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (sv[btb_index][w] && st[btb_index][w] == btb_tag) begin
                btb_hit       = 1'b1;
                btb_target_rd = stg[btb_index][w];
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state
    bit m_sweep;
    int m_cnt;
    int m_streak;
    bit m_rsp_v, m_rsp_hit, m_done;
    logic [GW-1:0] m_rsp_tgt;

    // Captured DUT outputs of the most recent step
    logic          c_lk_gnt, c_up_gnt, c_rd, c_wr, c_inv, c_busy, c_rsp_v, c_rsp_hit, c_done;
    logic [IW-1:0] c_idx;
    logic [TW-1:0] c_tag;
    logic [GW-1:0] c_tgt, c_rsp_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tbl_lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                              output bit hit, output logic [GW-1:0] tgt);
        hit = 1'b0;
        tgt = '0;
        for (int w = 0; w < WAYS; w++)
            if (sv[idx][w] && st[idx][w] == tag) begin
                hit = 1'b1;
                tgt = stg[idx][w];
            end
    endtask

    task automatic tbl_write(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                             input logic [GW-1:0] tgt);
        int way;
        way = rr[idx];
        for (int w = 0; w < WAYS; w++)
            if (sv[idx][w] && st[idx][w] == tag) way = w;
        if (way == rr[idx]) rr[idx] = (rr[idx] + 1) % WAYS;
        sv[idx][way]  = 1'b1;
        st[idx][way]  = tag;
        stg[idx][way] = tgt;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance model and BTB.
    task automatic step();
        bit e_lk, e_up, e_inv, e_busy, h;
        logic [IW-1:0] e_idx;
        logic [TW-1:0] e_tag;
        logic [GW-1:0] e_tgt, t;
        e_lk = 0; e_up = 0; e_inv = 0; e_busy = 0; e_idx = '0; e_tag = '0; e_tgt = '0;
        @(negedge clk);
        if (!rst) begin
            if (m_sweep) begin
                e_inv = 1; e_busy = 1; e_idx = IW'(m_cnt);
            end else if (inv_req) begin
                e_lk = 0;
            end else if (up_req && (!lk_req || m_streak < MAXS)) begin
                e_up = 1; e_idx = up_index; e_tag = up_tag; e_tgt = up_target;
            end else if (lk_req) begin
                e_lk = 1; e_idx = lk_index; e_tag = lk_tag;
            end
        end
        c_lk_gnt = lk_gnt; c_up_gnt = up_gnt; c_rd = btb_rd; c_wr = btb_wr; c_inv = btb_inv;
        c_busy = inv_busy; c_idx = btb_index; c_tag = btb_tag; c_tgt = btb_target;
        c_rsp_v = lk_rsp_valid; c_rsp_hit = lk_rsp_hit; c_rsp_tgt = lk_rsp_target;
        c_done = inv_done;
        chk("lk_gnt", 32'(c_lk_gnt), 32'(e_lk));
        chk("up_gnt", 32'(c_up_gnt), 32'(e_up));
        chk("btb_rd", 32'(c_rd), 32'(e_lk));
        chk("btb_wr", 32'(c_wr), 32'(e_up));
        chk("btb_inv", 32'(c_inv), 32'(e_inv));
        chk("inv_busy", 32'(c_busy), 32'(e_busy));
        chk("btb_index", 32'(c_idx), 32'(e_idx));
        chk("btb_tag", 32'(c_tag), 32'(e_tag));
        chk("btb_target", c_tgt, e_tgt);
        chk("rsp_valid", 32'(c_rsp_v), 32'(m_rsp_v));
        chk("rsp_hit", 32'(c_rsp_hit), 32'(m_rsp_hit));
        chk("rsp_target", c_rsp_tgt, m_rsp_tgt);
        chk("inv_done", 32'(c_done), 32'(m_done));
        tbl_lookup(lk_index, lk_tag, h, t);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_sweep = 0; m_cnt = 0; m_streak = 0;
            m_rsp_v = 0; m_rsp_hit = 0; m_rsp_tgt = '0; m_done = 0;
        end else begin
            m_rsp_v   = e_lk;
            m_rsp_hit = e_lk && h;
            m_rsp_tgt = (e_lk && h) ? t : '0;
            m_done    = m_sweep && !inv_req && m_cnt == N - 1;
            if (m_sweep) begin
                if (inv_req) m_cnt = 0;
                else if (m_cnt == N - 1) begin m_sweep = 0; m_cnt = 0; end
                else m_cnt++;
            end else if (inv_req) begin
                m_sweep = 1; m_cnt = 0; m_streak = 0;
            end else if (e_up) begin
                m_streak = lk_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            end else if (e_lk) begin
                m_streak = 0;
            end
        end
        if (c_wr) tbl_write(c_idx, c_tag, c_tgt);
        if (c_inv) for (int w = 0; w < WAYS; w++) sv[c_idx][w] = 1'b0;
    endtask

    int n, inv_cycles, done_at, gnt_at, restart_at, zero_at, dones;
    bit got;
    logic [5:0] seq;

    initial begin
        for (int s = 0; s < N; s++) begin
            rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                sv[s][w] = 1'b0; st[s][w] = '0; stg[s][w] = '0;
            end
        end
        m_sweep = 0; m_cnt = 0; m_streak = 0;
        m_rsp_v = 0; m_rsp_hit = 0; m_rsp_tgt = '0; m_done = 0;
        rst = 1; lk_req = 0; lk_index = '0; lk_tag = '0;
        up_req = 0; up_index = '0; up_tag = '0; up_target = '0; inv_req = 0;
        @(posedge clk); #1;
        step();
        // Reset state with requests presented: nothing may be granted.
        lk_req = 1; up_req = 1; inv_req = 1;
        step();
        chk("reset_no_gnt", 32'({c_lk_gnt, c_up_gnt, c_inv, c_busy}), 32'd0);
        lk_req = 0; up_req = 0; inv_req = 0; rst = 0;
        step();

        // Update only
        up_req = 1; up_index = 4'd7; up_tag = 5'h11; up_target = 32'hDEAD_BEE0;
        step();
        chk("upd_only_gnt", 32'({c_up_gnt, c_wr, c_idx, c_tag}), 32'({2'b11, 4'd7, 5'h11}));
        chk("upd_only_tgt", c_tgt, 32'hDEAD_BEE0);

        // Lookup hit, then miss
        up_index = 4'd3; up_tag = 5'h0A; up_target = 32'h0000_1040;
        step();
        up_req = 0;
        lk_req = 1; lk_index = 4'd3; lk_tag = 5'h0A;
        step();
        chk("lk_hit_gnt", 32'(c_lk_gnt), 32'd1);
        lk_req = 0;
        step();
        chk("lk_hit_rsp", 32'({c_rsp_v, c_rsp_hit}), 32'd3);
        chk("lk_hit_tgt", c_rsp_tgt, 32'h0000_1040);
        lk_req = 1; lk_tag = 5'h0B;
        step();
        lk_req = 0;
        step();
        chk("lk_miss_rsp", 32'({c_rsp_v, c_rsp_hit}), 32'd2);
        chk("lk_miss_tgt", c_rsp_tgt, 32'd0);

        // Starvation bound: both held for six cycles
        lk_req = 1; lk_index = 4'd2; lk_tag = 5'h01;
        up_req = 1; up_index = 4'd4; up_tag = 5'h02; up_target = 32'h0000_2000;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            seq = {seq[4:0], c_up_gnt & ~c_lk_gnt};
        end
        chk("starve_seq", 32'(seq), 32'(6'b110110));
        lk_req = 0; up_req = 0;
        step();

        // Sweep with lookup held
        lk_req = 1; lk_index = 4'd5; lk_tag = 5'h03; inv_req = 1;
        step();
        chk("sweep_wins", 32'({c_lk_gnt, c_up_gnt}), 32'd0);
        inv_req = 0; inv_cycles = 0; n = 0; got = 0; done_at = -1; gnt_at = -1;
        while (!got && n < 40) begin
            step(); n++;
            if (c_inv) begin
                chk("sweep_idx", 32'(c_idx), 32'(inv_cycles));
                inv_cycles++;
            end
            if (c_done) done_at = n;
            if (c_lk_gnt) begin gnt_at = n; got = 1; end
        end
        chk("sweep_len", 32'(inv_cycles), 32'd16);
        chk("sweep_done_at", 32'(done_at), 32'd17);
        chk("sweep_gnt_at", 32'(gnt_at), 32'd17);
        lk_req = 0;
        step();

        // Sweep restart at counter 9
        inv_req = 1;
        step();
        n = 0; restart_at = -1; zero_at = -1; done_at = -1;
        while (done_at < 0 && n < 60) begin
            inv_req = (m_sweep && m_cnt == 9 && restart_at < 0);
            step(); n++;
            if (inv_req) restart_at = n;
            if (restart_at >= 0 && zero_at < 0 && c_inv && c_idx == 0) zero_at = n;
            if (c_done) done_at = n;
        end
        inv_req = 0;
        chk("restart_zero", 32'(zero_at), 32'(restart_at + 1));
        chk("restart_done", 32'(done_at - zero_at), 32'd16);

        // Reset mid-sweep at counter 5
        inv_req = 1;
        step();
        inv_req = 0; n = 0;
        while (n < 40 && !(m_sweep && m_cnt == 5)) begin step(); n++; end
        rst = 1;
        step();
        rst = 0;
        step();
        chk("rst_mid_idle", 32'({c_inv, c_busy, c_idx}), 32'd0);
        lk_req = 1; lk_index = 4'd1; lk_tag = 5'h02;
        step();
        chk("rst_mid_gnt", 32'(c_lk_gnt), 32'd1);
        lk_req = 0; dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (c_done) dones++;
        end
        chk("rst_mid_nodone", 32'(dones), 32'd0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            if (!lk_req || c_lk_gnt) begin
                lk_req   = ($urandom_range(2, 0) != 0);
                lk_index = IW'($urandom_range(3, 0));
                lk_tag   = TW'($urandom_range(3, 0));
            end
            if (!up_req || c_up_gnt) begin
                up_req    = ($urandom_range(2, 0) == 0);
                up_index  = IW'($urandom_range(3, 0));
                up_tag    = TW'($urandom_range(3, 0));
                up_target = $urandom;
            end
            inv_req = ($urandom_range(59, 0) == 0);
            rst     = ($urandom_range(299, 0) == 0);
            step();
        end
        rst = 0; inv_req = 0; lk_req = 0; up_req = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
